toggle_event_counter: RTL

//   Downstream consumer of the t_latch output q. Synchronises q into the clk

---
 rtl/toggle_event_counter_if.sv | 23 ++
 rtl/toggle_event_counter.sv | 101 ++++++++++
 2 files changed

// File: rtl/toggle_event_counter_if.sv
// Handshake and result bundle between a toggle_event_counter and its consumer.
// The master side drives q_in, start and ack. The slave side returns status and the result.
interface toggle_event_counter_if #(
    parameter int CNT_W = 8
);
    logic             q_in;
    logic             start;
    logic             ack;
    logic             busy;
    logic             valid;
    logic [CNT_W-1:0] count;
    logic             overflow;

    modport master (
        output q_in, start, ack,
        input  busy, valid, count, overflow
    );

    modport slave (
        input  q_in, start, ack,
        output busy, valid, count, overflow
    );
endinterface

// File: rtl/toggle_event_counter.sv
// Counts toggles of an asynchronous latch output q over a fixed window of clk cycles.
// The result is handed to the consumer through a valid/ack handshake.
module toggle_event_counter #(
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 8,
    parameter int WINDOW      = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    toggle_event_counter_if.slave   bus
);
    localparam int TIMER_W = $clog2(WINDOW);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t                 state_r;
    logic [SYNC_STAGES-1:0] sync_r;
    logic                   q_s;
    logic                   q_s_d_r;
    logic                   edge_s;
    logic [TIMER_W-1:0]     timer_r;
    logic [CNT_W-1:0]       count_r;
    logic                   overflow_r;
    logic                   busy_r;
    logic                   valid_r;

    // Synchroniser and edge-delay flop. These run in every state, so a level
    // that is already present at start is never seen as a toggle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_r  <= '0;
            q_s_d_r <= 1'b0;
        end else begin
            sync_r  <= {sync_r[SYNC_STAGES-2:0], bus.q_in};
            q_s_d_r <= q_s;
        end
    end

    assign q_s    = sync_r[SYNC_STAGES-1];
    assign edge_s = q_s ^ q_s_d_r;

    // Measurement FSM. busy and valid are registered alongside the state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r    <= IDLE;
            timer_r    <= '0;
            count_r    <= '0;
            overflow_r <= 1'b0;
            busy_r     <= 1'b0;
            valid_r    <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (bus.start) begin
                        state_r    <= COUNT;
                        busy_r     <= 1'b1;
                        count_r    <= '0;
                        overflow_r <= 1'b0;
                        timer_r    <= '0;
                    end
                end
                COUNT: begin
                    timer_r <= timer_r + TIMER_W'(1);
                    if (edge_s) begin
                        if (&count_r) begin
                            overflow_r <= 1'b1;
                        end else begin
                            count_r <= count_r + CNT_W'(1);
                        end
                    end
                    // An edge on this final cycle is still counted above.
                    if (timer_r == TIMER_W'(WINDOW - 1)) begin
                        state_r <= DONE;
                        busy_r  <= 1'b0;
                        valid_r <= 1'b1;
                    end
                end
                DONE: begin
                    if (bus.ack) begin
                        state_r <= IDLE;
                        valid_r <= 1'b0;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    busy_r  <= 1'b0;
                    valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy     = busy_r;
    assign bus.valid    = valid_r;
    assign bus.count    = count_r;
    assign bus.overflow = overflow_r;
endmodule
